// File: rtl/bm_pkg.sv
// Shared widths, types and helpers for the Box-Muller output stage.
package bm_pkg;

  localparam int F_W    = 17;
  localparam int F_FRAC = 13;
  localparam int G_W    = 16;
  localparam int G_FRAC = 14;
  localparam int X_W    = 16;
  localparam int X_FRAC = 11;

  // f is zero-extended by one bit so both multiplies are plain signed ones.
  localparam int P_W    = F_W + 1 + G_W;
  localparam int P_FRAC = F_FRAC + G_FRAC;

  localparam int SAT_W  = 16;

  typedef logic signed [P_W-1:0] prod_t;
  typedef logic signed [X_W-1:0] sample_t;

  typedef struct packed {
    sample_t x0;
    sample_t x1;
  } pair_t;

  // Adds 0..2 clamp events to the counter, sticking at all-ones.
  function automatic logic [SAT_W-1:0] sat_add(input logic [SAT_W-1:0] acc,
                                               input logic [1:0]       inc);
    logic [SAT_W:0] sum;
    sum = {1'b0, acc} + {{(SAT_W-1){1'b0}}, inc};
    return sum[SAT_W] ? {SAT_W{1'b1}} : sum[SAT_W-1:0];
  endfunction

endpackage

// File: rtl/bm_round_sat.sv
// Round-half-up and saturate one signed product down to a 16-bit sample.
module bm_round_sat import bm_pkg::*; #(
  parameter int SHIFT = P_FRAC - X_FRAC
) (
  input  prod_t   p,
  output sample_t x,
  output logic    sat
);

  localparam int             R_W  = P_W + 1 - SHIFT;
  localparam logic [P_W:0]   HALF = (P_W + 1)'(1) << (SHIFT - 1);

  logic signed [P_W:0]   biased;
  logic signed [R_W-1:0] r;
  logic [R_W-X_W:0]      hi;

  always_comb begin
    biased = $signed({p[P_W-1], p}) + $signed(HALF);
    r      = R_W'(biased >>> SHIFT);
    // The value fits in X_W bits only if every bit above the sample's sign bit matches it.
    hi     = r[R_W-1:X_W-1];
    sat    = !((&hi) || !(|hi));
    if (!sat)          x = r[X_W-1:0];
    else if (r[R_W-1]) x = {1'b1, {(X_W-1){1'b0}}};
    else               x = {1'b0, {(X_W-1){1'b1}}};
  end

endmodule

// File: rtl/bm_out_stage.sv
// Box-Muller output stage: multiplies f by g0/g1, rounds and saturates,
// buffers the pairs and serializes them as x0 then x1 on one sample stream.
module bm_out_stage import bm_pkg::*; #(
  parameter int FIFO_DEPTH = 4,   // pairs; power of two, >= 2
  parameter int OUT_FRAC   = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [F_W-1:0]   f_in,
  input  logic [G_W-1:0]   g0_in,
  input  logic [G_W-1:0]   g1_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [X_W-1:0]   out_data,
  output logic             out_sel,
  output logic [SAT_W-1:0] sat_count
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both
  // high; valid never waits on ready, and the payload is held while valid && !ready.

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic                    s1_valid;
  logic [F_W-1:0]          s1_f;
  logic signed [G_W-1:0]   s1_g0;
  logic signed [G_W-1:0]   s1_g1;

  logic                    s2_valid;
  prod_t                   s2_p0;
  prod_t                   s2_p1;

  sample_t                 x0_rs;
  sample_t                 x1_rs;
  logic                    sat0;
  logic                    sat1;

  pair_t                   mem [FIFO_DEPTH];
  pair_t                   head;
  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           rd_ptr;
  logic [CW-1:0]           count;
  logic [CW:0]             credits;

  logic                    accept;
  logic                    wr;
  logic                    pop;

  bm_round_sat #(.SHIFT(P_FRAC - OUT_FRAC)) u_rs0 (
    .p   (s2_p0),
    .x   (x0_rs),
    .sat (sat0)
  );

  bm_round_sat #(.SHIFT(P_FRAC - OUT_FRAC)) u_rs1 (
    .p   (s2_p1),
    .x   (x1_rs),
    .sat (sat1)
  );

  // Every pair in S1/S2 already owns a FIFO slot, so the pipeline never has to stall.
  always_comb begin
    credits  = {1'b0, count} + (CW + 1)'(s1_valid) + (CW + 1)'(s2_valid);
    in_ready = credits < (CW + 1)'(FIFO_DEPTH);
    accept   = in_valid && in_ready;
    wr       = s2_valid;
    out_valid = count != '0;
    pop      = out_valid && out_ready && out_sel;
    head     = mem[rd_ptr];
    out_data = '0;
    if (out_valid) out_data = out_sel ? head.x1 : head.x0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_sel   <= 1'b0;
      sat_count <= '0;
    end else begin
      s1_valid <= accept;
      s2_valid <= s1_valid;
      if (wr) begin
        wr_ptr    <= wr_ptr + 1'b1;
        sat_count <= sat_add(sat_count, {1'b0, sat0} + {1'b0, sat1});
      end
      if (out_valid && out_ready) begin
        out_sel <= !out_sel;
        if (out_sel) rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Datapath registers carry no reset; their valid bits above qualify them.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_f  <= f_in;
      s1_g0 <= g0_in;
      s1_g1 <= g1_in;
    end
    if (s1_valid) begin
      s2_p0 <= $signed({1'b0, s1_f}) * s1_g0;
      s2_p1 <= $signed({1'b0, s1_f}) * s1_g1;
    end
    if (wr) mem[wr_ptr] <= {x0_rs, x1_rs};
  end

endmodule
